qpsk_tx_chain: RTL and testbench

Single-clock transmit path for one QPSK rail.
- An internal PRBS9 generator produces one data bit per symbol period.
- Each bit is mapped to ±1 and shaped by a 4x-oversampled polyphase raised-cosine FIR (roll-off 0.5, 6-symbol span).
- Output is one 8-bit signed sample per clock, feeding the DAC/upsampler stage.

---
 rtl/qpsk_tx_pkg.sv | 40 ++++
 rtl/prbs9_lfsr.sv | 33 +++
 rtl/qpsk_tx_chain.sv | 108 ++++++++++
 tb/tb_qpsk_tx_chain.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/qpsk_tx_pkg.sv
// qpsk_tx_pkg
// Shared constants for the single-rail QPSK transmit chain: oversampling,
// filter span, data widths, default LFSR seed, the 24-tap raised-cosine
// coefficient table and the ternary symbol type used by the shaping filter.
// Optional feature macro used by the chain: EXT_BIT_EN.

package qpsk_tx_pkg;

  localparam int OS     = 4;
  localparam int NBAUD  = 6;
  localparam int NTAPS  = OS * NBAUD;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 8;
  localparam int ACC_W  = 16;

  localparam logic [8:0] SEED_DEFAULT = 9'b010101011;

  // Symbol values are restricted to -1, 0 and +1.
  typedef logic signed [1:0] sym_t;

  localparam sym_t SYM_POS = 2'sd1;
  localparam sym_t SYM_NEG = -2'sd1;

  // h[k] = round(127 * rc((k-12)/4)), beta = 0.5, T = 1.
  // Every fourth tap lands on a symbol-spaced zero crossing except the centre.
  localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
    8'sd0,   8'sd1,   8'sd2,   8'sd3,
    8'sd0,  -8'sd7,  -8'sd15, -8'sd16,
    8'sd0,   8'sd33,  8'sd76,  8'sd113,
    8'sd127, 8'sd113, 8'sd76,  8'sd33,
    8'sd0,  -8'sd16, -8'sd15, -8'sd7,
    8'sd0,   8'sd3,   8'sd2,   8'sd1
  };

  // Bit 0 maps to +1, bit 1 maps to -1.
  function automatic sym_t map_bit(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// prbs9_lfsr
// Fibonacci PRBS9 generator, polynomial x^9 + x^5 + 1. Advances one step on
// each clock where en is high; output is the register MSB.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-low reset (loads SEED)
//   en     in   advance enable
//   o_bit  out  current PRBS bit (lfsr[8])

module prbs9_lfsr
  import qpsk_tx_pkg::*;
#(
  parameter logic [8:0] SEED = SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic o_bit
);

  logic [8:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (en) begin
      r_lfsr <= {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};
    end
  end

  assign o_bit = r_lfsr[8];

endmodule

// File: rtl/qpsk_tx_chain.sv
// qpsk_tx_chain
// One QPSK rail: PRBS9 data bits, one per 4-clock symbol period, mapped to
// +/-1 and shaped by a 4x polyphase raised-cosine FIR (24 taps, 6 symbols).
// One 8-bit signed sample leaves per clock.
// Ports:
//   clk     in   sample clock
//   rst     in   asynchronous active-low reset
//   i_bit   in   external data bit (only when EXT_BIT_EN is defined)
//   o_prbs  out  current PRBS bit
//   o_tx    out  filtered sample, signed two's complement
// Macro EXT_BIT_EN: when defined, the symbol register loads i_bit instead of
// the PRBS bit; the PRBS generator and o_prbs keep running regardless.

module qpsk_tx_chain
  import qpsk_tx_pkg::*;
#(
  parameter logic [8:0] SEED = SEED_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef EXT_BIT_EN
  input  logic                    i_bit,
`endif
  output logic                    o_prbs,
  output logic signed [OUT_W-1:0] o_tx
);

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] x);
    if (x > OUT_MAX) begin
      return OUT_MAX[OUT_W-1:0];
    end else if (x < OUT_MIN) begin
      return OUT_MIN[OUT_W-1:0];
    end else begin
      return x[OUT_W-1:0];
    end
  endfunction

  logic [1:0]              r_phase;
  sym_t                    r_sym [NBAUD];
  logic                    w_step;
  logic                    w_bit_in;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_shift;

  // Symbol boundary: the last clock of each 4-clock symbol period.
  assign w_step = (r_phase == 2'd3);

  prbs9_lfsr #(
    .SEED (SEED)
  ) u_prbs (
    .clk   (clk),
    .rst   (rst),
    .en    (w_step),
    .o_bit (o_prbs)
  );

`ifdef EXT_BIT_EN
  assign w_bit_in = i_bit;
`else
  assign w_bit_in = o_prbs;
`endif

  // Phase counter and symbol delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= 2'd0;
      for (int j = 0; j < NBAUD; j++) begin
        r_sym[j] <= '0;
      end
    end else begin
      r_phase <= r_phase + 2'd1;
      if (w_step) begin
        r_sym[0] <= map_bit(w_bit_in);
        for (int j = 1; j < NBAUD; j++) begin
          r_sym[j] <= r_sym[j-1];
        end
      end
    end
  end

  // Polyphase branch p uses taps h[4j+p]; with ternary symbols each product
  // reduces to add, subtract or skip.
  always_comb begin
    w_acc = '0;
    for (int j = 0; j < NBAUD; j++) begin
      case (r_sym[j])
        SYM_POS: w_acc = w_acc + ACC_W'(COEF[5'(OS * j) + 5'(r_phase)]);
        SYM_NEG: w_acc = w_acc - ACC_W'(COEF[5'(OS * j) + 5'(r_phase)]);
        default: ;
      endcase
    end
  end

  assign w_shift = w_acc >>> 1;

  // Output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_tx <= '0;
    end else begin
      o_tx <= sat_out(w_shift);
    end
  end

endmodule

// File: tb/tb_qpsk_tx_chain.sv
// tb_qpsk_tx_chain
// Directed bench for qpsk_tx_chain: reset values, PRBS start sequence and
// period, centre-tap values, cycle-by-cycle comparison with an independent
// bit-exact model, asynchronous mid-run reset, and (with EXT_BIT_EN) the
// settled constant-input patterns.

module tb_qpsk_tx_chain;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              o_prbs;
  logic signed [7:0] o_tx;
`ifdef EXT_BIT_EN
  logic              tb_bit = 1'b0;
  bit                follow = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpsk_tx_chain dut (
    .clk    (clk),
    .rst    (rst),
`ifdef EXT_BIT_EN
    .i_bit  (tb_bit),
`endif
    .o_prbs (o_prbs),
    .o_tx   (o_tx)
  );

  // Hand-derived round(127*rc((k-12)/4)), beta = 0.5.
  int H    [24] = '{0, 1, 2, 3, 0, -7, -15, -16, 0, 33, 76, 113,
                    127, 113, 76, 33, 0, -16, -15, -7, 0, 3, 2, 1};
  int EXP9 [9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
  int EXT1 [4]  = '{-64, -64, -63, -64};

  logic [8:0] m_lfsr;
  int         m_phase;
  int         m_sym [6];
  int         m_tx;
  bit         hist [$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 9'b010101011;
    m_phase = 0;
    for (int j = 0; j < 6; j++) m_sym[j] = 0;
    m_tx = 0;
    hist.delete();
  endtask

  task automatic model_step();
    int acc;
    bit b;
    acc = 0;
    for (int j = 0; j < 6; j++) acc += m_sym[j] * H[4*j + m_phase];
    acc = acc >>> 1;
    m_tx = (acc > 127) ? 127 : ((acc < -128) ? -128 : acc);
    if (m_phase == 3) begin
`ifdef EXT_BIT_EN
      b = tb_bit;
`else
      b = m_lfsr[8];
`endif
      for (int j = 5; j > 0; j--) m_sym[j] = m_sym[j-1];
      m_sym[0] = b ? -1 : 1;
      m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    end
    m_phase = (m_phase + 1) % 4;
  endtask

  // One clock: update the model with the pre-edge state, then compare #1 later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    chk("golden_tx", o_tx, m_tx);
    chk("golden_prbs", o_prbs, m_lfsr[8]);
`ifdef EXT_BIT_EN
    if (follow) tb_bit = m_lfsr[8];
`endif
  endtask

  initial begin
    // Reset held for 8 clocks
    model_reset();
    rst = 1'b0;
    repeat (8) tick();
    chk("rst_tx", o_tx, 0);
    chk("rst_prbs", o_prbs, 0);
    @(negedge clk);
    rst = 1'b1;

    // Long run: golden model, centre tap, PRBS history
    for (int c = 0; c < 2100; c++) begin
      tick();
      if (m_phase == 3) hist.push_back(o_prbs);
      if (m_phase == 1 && hist.size() >= 4)
        chk("centre", o_tx, hist[hist.size()-4] ? -64 : 63);
    end
    for (int k = 0; k < 9; k++) chk("prbs_first9", hist[k], EXP9[k]);
    for (int n = 511; n < hist.size(); n++) chk("prbs_period", hist[n], hist[n-511]);
    for (int n = 8; n < hist.size(); n++) begin
      bit any1;
      any1 = 1'b0;
      for (int i = 0; i < 9; i++) any1 |= hist[n-i];
      chk("prbs_nonzero", any1, 1);
    end

    // Asynchronous reset in the middle of a clock period
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", o_tx, 0);
    chk("arst_prbs", o_prbs, 0);
    model_reset();
    repeat (3) tick();
    #3 rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m_phase == 3) hist.push_back(o_prbs);
    end
    for (int k = 0; k < 9; k++) chk("restart_first9", hist[k], EXP9[k]);

`ifdef EXT_BIT_EN
    // Constant external bit: all-+1 then all--1 symbol history
    follow = 1'b0;
    tb_bit = 1'b0;
    repeat (40) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ext0_pattern", o_tx, 63);
    end
    tb_bit = 1'b1;
    repeat (40) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ext1_pattern", o_tx, EXT1[(m_phase + 3) % 4]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
